// File: rtl/modexp_ctrl_if.sv
// Start/done handshake between the exponentiation sequencer (master)
// and the Montgomery multiplier it drives (slave).
interface modexp_ctrl_if #(
  parameter int N = 1024
);
  logic         mont_start;
  logic [N-1:0] mont_a;
  logic [N-1:0] mont_b;
  logic [N-1:0] mont_m;
  logic [N:0]   mont_result;
  logic         mont_done;

  modport master (
    output mont_start, mont_a, mont_b, mont_m,
    input  mont_result, mont_done
  );

  modport slave (
    input  mont_start, mont_a, mont_b, mont_m,
    output mont_result, mont_done
  );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for X^E mod M.
// Operands arrive in Montgomery form; every modular product goes to an external
// Montgomery multiplier, and a final multiply by 1 leaves the Montgomery domain.
module modexp_ctrl #(
  parameter int N       = 1024,
  parameter int E_WIDTH = 1024,
  parameter int LEN_W   = 11
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N-1:0]       in_xm,
  input  logic [N-1:0]       in_rm,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]   e_len,
  input  logic [N-1:0]       in_m,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       result,
  output logic               ovf,
  modexp_ctrl_if.master      mont
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_SQ_ISSUE,
    S_SQ_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_POST_ISSUE,
    S_POST_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [N-1:0]       r_result;
  logic               r_ovf;
  logic               r_mont_start;
  logic [N-1:0]       r_mont_a;
  logic [N-1:0]       r_mont_b;
  logic [N-1:0]       r_mont_m;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_xm;
  logic [E_WIDTH-1:0] r_e;
  logic [LEN_W-1:0]   r_idx;

  logic [LEN_W-1:0]   w_len;
  logic [E_WIDTH-1:0] w_e_sh;
  logic               w_ebit;
  logic [N-1:0]       w_prod;
  logic               w_prod_ovf;

  // Exponent lengths beyond the exponent register are clamped to its width.
  assign w_len      = (e_len > LEN_W'(E_WIDTH)) ? LEN_W'(E_WIDTH) : e_len;
  // Bit idx of the exponent, taken by shifting to avoid an oversize index.
  assign w_e_sh     = r_e >> r_idx;
  assign w_ebit     = w_e_sh[0];
  assign w_prod     = mont.mont_result[N-1:0];
  assign w_prod_ovf = mont.mont_result[N];

  assign busy            = r_busy;
  assign done            = r_done;
  assign result          = r_result;
  assign ovf             = r_ovf;
  assign mont.mont_start = r_mont_start;
  assign mont.mont_a     = r_mont_a;
  assign mont.mont_b     = r_mont_b;
  assign mont.mont_m     = r_mont_m;

  // Sequencer: operands and the start pulse are registered on entry to each ISSUE state
  // so they are valid during ISSUE and remain frozen through the matching WAIT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_mont_start <= 1'b0;
      r_mont_a     <= '0;
      r_mont_b     <= '0;
      r_mont_m     <= '0;
      r_a          <= '0;
      r_xm         <= '0;
      r_e          <= '0;
      r_idx        <= '0;
    end else begin
      r_done       <= 1'b0;
      r_mont_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_xm     <= in_xm;
            r_a      <= in_rm;
            r_e      <= in_e;
            r_idx    <= w_len;
            r_mont_m <= in_m;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_mont_a     <= r_a;
          r_mont_start <= 1'b1;
          if (r_idx == '0) begin
            r_mont_b <= N'(1);
            r_state  <= S_POST_ISSUE;
          end else begin
            r_idx    <= r_idx - 1'b1;
            r_mont_b <= r_a;
            r_state  <= S_SQ_ISSUE;
          end
        end
        S_SQ_ISSUE:  r_state <= S_SQ_WAIT;
        S_SQ_WAIT: begin
          if (mont.mont_done) begin
            r_a <= w_prod;
            if (w_prod_ovf) r_ovf <= 1'b1;
            if (w_ebit) begin
              r_mont_a     <= w_prod;
              r_mont_b     <= r_xm;
              r_mont_start <= 1'b1;
              r_state      <= S_MUL_ISSUE;
            end else begin
              r_state <= S_CHECK;
            end
          end
        end
        S_MUL_ISSUE: r_state <= S_MUL_WAIT;
        S_MUL_WAIT: begin
          if (mont.mont_done) begin
            r_a <= w_prod;
            if (w_prod_ovf) r_ovf <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_POST_ISSUE: r_state <= S_POST_WAIT;
        S_POST_WAIT: begin
          if (mont.mont_done) begin
            r_result <= w_prod;
            if (w_prod_ovf) r_ovf <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl with a behavioural Montgomery multiplier responder
// (programmable latency) and a scoreboard of expected exponentiation results.
module tb_modexp_ctrl;
  localparam int N  = 8;
  localparam int EW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [N-1:0]  in_xm, in_rm, in_m;
  logic [EW-1:0] in_e;
  logic [LW-1:0] e_len;
  logic          busy, done, ovf;
  logic [N-1:0]  result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] res;
    int           pulses;
    logic         ovf;
  } exp_t;
  exp_t sb[$];

  // responder state
  int           lat = 1;
  int           cnt = 0;
  int           pulse_cnt = 0;
  int           stab_bad = 0;
  logic [N-1:0] cap_a, cap_b, cap_m;
  logic [N-1:0] first_a, first_b;
  bit           spur_arm = 0, spur_pend = 0, ovf_once = 0;

  always #5 clk = ~clk;

  modexp_ctrl_if #(.N(N)) mif ();

  modexp_ctrl #(.N(N), .E_WIDTH(EW), .LEN_W(LW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_xm  (in_xm),
    .in_rm  (in_rm),
    .in_e   (in_e),
    .e_len  (e_len),
    .in_m   (in_m),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .mont   (mif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m);
    int t;
    t = int'(a) * int'(b);
    for (int i = 0; i < N; i++) begin
      if (t % 2 == 1) t = t + int'(m);
      t = t / 2;
    end
    if (t >= int'(m)) t = t - int'(m);
    return t[N-1:0];
  endfunction

  function automatic int ref_pow(input int x, input int e, input int len, input int m);
    int r;
    r = 1 % m;
    for (int i = len - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (((e >> i) & 1) == 1) r = (r * x) % m;
    end
    return r;
  endfunction

  // Behavioural multiplier: sees mont_start at the falling edge and answers lat cycles later.
  initial begin
    mif.mont_done   = 1'b0;
    mif.mont_result = '0;
    forever begin
      @(negedge clk);
      mif.mont_done = 1'b0;
      if (!resetn) begin
        cnt       = 0;
        spur_pend = 0;
      end else begin
        if (cnt > 0 && (mif.mont_a !== cap_a || mif.mont_b !== cap_b || mif.mont_m !== cap_m))
          stab_bad++;
        if (spur_pend) begin
          mif.mont_done   = 1'b1;
          mif.mont_result = 9'h1AB;
          spur_pend       = 0;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mif.mont_result = {ovf_once, mont_ref(cap_a, cap_b, cap_m)};
            mif.mont_done   = 1'b1;
            ovf_once        = 0;
            if (spur_arm && pulse_cnt >= 3) begin
              spur_pend = 1;
              spur_arm  = 0;
            end
          end
        end
        if (mif.mont_start) begin
          cap_a = mif.mont_a;
          cap_b = mif.mont_b;
          cap_m = mif.mont_m;
          if (pulse_cnt == 0) begin
            first_a = mif.mont_a;
            first_b = mif.mont_b;
          end
          pulse_cnt++;
          cnt = lat;
        end
      end
    end
  end

  task automatic drive_ops(input int m, input int x, input int e, input int len);
    in_m  = m[N-1:0];
    in_rm = 8'((256 % m));
    in_xm = 8'(((x * 256) % m));
    in_e  = e[EW-1:0];
    e_len = len[LW-1:0];
  endtask

  task automatic run_op(input int m, input int x, input int e, input int len, input int l,
                        input bit poke, input bit spur, input bit ovfi);
    exp_t s, g;
    int   eff, pc, cyc;
    eff = (len > EW) ? EW : len;
    pc  = 0;
    for (int i = 0; i < eff; i++) if (((e >> i) & 1) == 1) pc++;
    s.res    = 8'(ref_pow(x, e, eff, m));
    s.pulses = eff + pc + 1;
    s.ovf    = ovfi;
    sb.push_back(s);
    lat = l; spur_arm = spur; ovf_once = ovfi; pulse_cnt = 0; stab_bad = 0;
    @(negedge clk);
    drive_ops(m, x, e, len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ovf_cleared", ovf, 0);
    if (poke) begin
      repeat (5) @(negedge clk);
      in_xm = 8'h77; in_e = 8'h3C; e_len = 4'd2; in_rm = 8'h01; in_m = 8'h0B;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    g = sb.pop_front();
    if (done !== 1'b1) begin
      check("done_timeout", 0, 1);
    end else begin
      check("result", result, g.res);
      check("pulses", pulse_cnt, g.pulses);
      check("ovf_at_done", ovf, g.ovf);
      check("wait_stable", stab_bad, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("result_held", result, g.res);
    end
  endtask

  initial begin
    int dcnt, cyc;
    resetn = 1'b0; start = 1'b0;
    in_xm = '0; in_rm = '0; in_m = '0; in_e = '0; e_len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    check("rst_mont_start", mif.mont_start, 0);
    check("rst_mont_a", mif.mont_a, 0);
    check("rst_mont_b", mif.mont_b, 0);
    check("rst_mont_m", mif.mont_m, 0);
    resetn = 1'b1;

    // 1: basic
    run_op(13, 2, 5, 3, 1, 0, 0, 0);
    // 2: e_len = 0, only the post multiply
    run_op(13, 2, 5, 0, 2, 0, 0, 0);
    check("len0_first_a", first_a, 8'(256 % 13));
    check("len0_first_b", first_b, 1);
    // 3: all-ones exponent, short and long multiplier latency
    run_op(13, 2, 8'hFF, 8, 1, 0, 0, 0);
    run_op(13, 2, 8'hFF, 8, 40, 0, 0, 0);
    // other patterns and e_len clamping
    run_op(11, 7, 8'hA3, 8, 2, 0, 0, 0);
    run_op(251, 200, 8'h5D, 7, 3, 0, 0, 0);
    run_op(13, 3, 8'hB5, 12, 1, 0, 0, 0);
    run_op(13, 2, 8'hFA, 3, 1, 0, 0, 0);
    // 4: start while busy plus a spurious mont_done
    run_op(13, 2, 8'hFF, 8, 3, 1, 1, 0);

    // 5: reset during SQ_WAIT
    lat = 20; pulse_cnt = 0; stab_bad = 0;
    @(negedge clk);
    drive_ops(13, 2, 5, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (pulse_cnt < 1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_sq", pulse_cnt, 1);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_mont_start", mif.mont_start, 0);
    resetn = 1'b1;
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run_op(13, 2, 5, 3, 1, 0, 0, 0);

    // 6: overflow bit from the multiplier, then cleared by the next start
    run_op(13, 2, 5, 3, 2, 0, 0, 1);
    run_op(13, 2, 5, 3, 2, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
